// File: rtl/alu_pkg.sv
// Shared ALU types: FSM states, add/sub mode encoding and the result-flag bundle.
// Reused by the add/sub unit and the planned shifter and multiplier units.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef struct packed {
      logic carry;
      logic overFlow;
      logic zero;
      logic negative;
   } flags_t;

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit add/sub slice: s = a + (mode ? ~b : b) + ci.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module addsub_slice
   import alu_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             mode,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [SLICE-1:0] w_b;
   logic [SLICE:0]   w_sum;

   always_comb begin
      w_b   = (mode == MODE_ADD) ? b : ~b;
      w_sum = {1'b0, a} + {1'b0, w_b} + {{SLICE{1'b0}}, ci};
   end

   assign s        = w_sum[SLICE-1:0];
   assign co       = w_sum[SLICE];
   // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out without a second adder.
   assign c_msb_in = a[SLICE-1] ^ w_b[SLICE-1] ^ w_sum[SLICE-1];

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/sub, SLICE bits per cycle LSB first; outValid NSLICE edges after accept.
// Result and flags hold in DONE until outReady; no new operand until the cycle after that handshake.
module addsub_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inValid,
   output logic             inReady,
   input  logic [WIDTH-1:0] inA,
   input  logic [WIDTH-1:0] inB,
   input  logic             mode,
   input  logic             useCarry,
   input  logic             cin,
   output logic             outValid,
   input  logic             outReady,
   output logic [WIDTH-1:0] out,
   output logic             carry,
   output logic             overFlow,
   output logic             zero,
   output logic             negative
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   generate
      if (WIDTH % SLICE != 0) begin : g_bad_slice
         $error("addsub_seq: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_out;
   logic             r_mode, r_carry, r_zacc;
   logic [CNT_W-1:0] r_cnt;
   flags_t           r_flags;

   logic             w_in_rdy, w_out_vld, w_last;
   logic [IDX_W-1:0] w_base;
   logic [SLICE-1:0] w_s;
   logic             w_co, w_c_msb;

   assign w_last = (r_cnt == LAST);
   assign w_base = IDX_W'(r_cnt) * IDX_W'(SLICE);

   addsub_slice #(.SLICE(SLICE)) u_slice (
      .a        (r_a[w_base +: SLICE]),
      .b        (r_b[w_base +: SLICE]),
      .mode     (r_mode),
      .ci       (r_carry),
      .s        (w_s),
      .co       (w_co),
      .c_msb_in (w_c_msb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_in_rdy  = 1'b0;
      w_out_vld = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_rdy = 1'b1;
            if (inValid) w_next = RUN;
         end
         RUN: begin
            if (w_last) w_next = DONE;
         end
         DONE: begin
            w_out_vld = 1'b1;
            if (outReady) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_out   <= '0;
         r_mode  <= MODE_ADD;
         r_carry <= 1'b0;
         r_zacc  <= 1'b0;
         r_cnt   <= '0;
         r_flags <= '0;
      end else if (r_state == IDLE && inValid) begin
         r_a     <= inA;
         r_b     <= inB;
         r_mode  <= mode;
         r_carry <= useCarry ? cin : (mode == MODE_SUB);
         r_out   <= '0;
         r_zacc  <= 1'b1;
         r_cnt   <= '0;
      end else if (r_state == RUN) begin
         r_out[w_base +: SLICE] <= w_s;
         r_carry <= w_co;
         r_zacc  <= r_zacc & (w_s == '0);
         r_cnt   <= r_cnt + 1'b1;
         // Flags only move on the final slice so they survive DONE and the return to IDLE.
         if (w_last) begin
            r_flags.carry    <= w_co;
            r_flags.overFlow <= w_c_msb ^ w_co;
            r_flags.zero     <= r_zacc & (w_s == '0);
            r_flags.negative <= w_s[SLICE-1];
         end
      end
   end

   assign inReady  = w_in_rdy;
   assign outValid = w_out_vld;
   assign out      = r_out;
   assign carry    = r_flags.carry;
   assign overFlow = r_flags.overFlow;
   assign zero     = r_flags.zero;
   assign negative = r_flags.negative;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: a 32/8 and a 64/16 instance share stimulus; sel picks the one being driven.
module tb_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        inValid = 1'b0, mode = 1'b0, useCarry = 1'b0, cin = 1'b0, outReady = 1'b1;
   logic [63:0] inA = '0, inB = '0;

   logic        inReady32, outValid32, carry32, ovf32, zero32, neg32;
   logic [31:0] out32;
   logic        inReady64, outValid64, carry64, ovf64, zero64, neg64;
   logic [63:0] out64;

   logic        v_inReady, v_outValid;
   logic [63:0] v_out;
   logic [3:0]  v_flags;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   addsub_seq #(.WIDTH(32), .SLICE(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .inValid(inValid & ~sel), .inReady(inReady32),
      .inA(inA[31:0]), .inB(inB[31:0]), .mode(mode), .useCarry(useCarry), .cin(cin),
      .outValid(outValid32), .outReady(outReady), .out(out32), .carry(carry32),
      .overFlow(ovf32), .zero(zero32), .negative(neg32)
   );

   addsub_seq #(.WIDTH(64), .SLICE(16)) dut64 (
      .clk(clk), .rst_n(rst_n), .inValid(inValid & sel), .inReady(inReady64),
      .inA(inA), .inB(inB), .mode(mode), .useCarry(useCarry), .cin(cin),
      .outValid(outValid64), .outReady(outReady), .out(out64), .carry(carry64),
      .overFlow(ovf64), .zero(zero64), .negative(neg64)
   );

   always_comb begin
      if (sel) begin
         v_inReady  = inReady64;
         v_outValid = outValid64;
         v_out      = out64;
         v_flags    = {carry64, ovf64, zero64, neg64};
      end else begin
         v_inReady  = inReady32;
         v_outValid = outValid32;
         v_out      = {32'h0, out32};
         v_flags    = {carry32, ovf32, zero32, neg32};
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Plain w-bit arithmetic: result, unsigned carry, and signed overflow from operand/result signs.
   function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic m,
                                 input logic uc, input logic ci, input int w,
                                 output logic [63:0] r, output logic [3:0] f);
      logic [63:0] mask, aa, bb;
      logic [64:0] full;
      logic        c, ov;
      mask = (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'h1 << w) - 64'h1);
      aa   = a & mask;
      bb   = (m ? ~b : b) & mask;
      full = {1'b0, aa} + {1'b0, bb} + {64'h0, (uc ? ci : m)};
      r    = full[63:0] & mask;
      c    = full[w];
      ov   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
      f    = {c, ov, (r == 64'h0), r[w-1]};
   endfunction

   task automatic wait_done(output int lat);
      lat = 0;
      while (!v_outValid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (lat >= 100) check("outValid_timeout", 64'(v_outValid), 64'h1);
   endtask

   task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic m,
                         input logic uc, input logic ci,
                         output logic [63:0] r, output logic [3:0] f, output int lat);
      int k = 0;
      inA = a; inB = b; mode = m; useCarry = uc; cin = ci; inValid = 1'b1;
      while (!v_inReady && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 100) check("inReady_timeout", 64'(v_inReady), 64'h1);
      @(posedge clk); #1;
      // Operands change right after the accepting edge and must not disturb the result.
      inValid = 1'b0;
      inA = {$urandom, $urandom}; inB = {$urandom, $urandom};
      mode = ~m; useCarry = ~uc; cin = ~ci;
      wait_done(lat);
      r = v_out;
      f = v_flags;
   endtask

   task automatic consume();
      outReady = 1'b1;
      @(posedge clk); #1;
      check("outValid_drop", 64'(v_outValid), 64'h0);
   endtask

   typedef struct {
      logic        s;
      logic [63:0] a, b;
      logic        m, uc, ci;
      logic [63:0] er;
      logic [3:0]  ef;
   } vec_t;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        dir[7];
      logic [63:0] r, er;
      logic [3:0]  f, ef;
      int          lat;

      // flags field order: {carry, overFlow, zero, negative}
      dir[0] = '{1'b0, 64'hffffffff, 64'h1,        1'b0, 1'b0, 1'b0, 64'h0,        4'b1010};
      dir[1] = '{1'b0, 64'h7fffffff, 64'h7fffffff, 1'b0, 1'b0, 1'b0, 64'hfffffffe, 4'b0101};
      dir[2] = '{1'b0, 64'h80000000, 64'h80000000, 1'b0, 1'b0, 1'b0, 64'h0,        4'b1110};
      dir[3] = '{1'b0, 64'h80000000, 64'h1,        1'b1, 1'b0, 1'b0, 64'h7fffffff, 4'b1100};
      dir[4] = '{1'b0, 64'h0,        64'h1,        1'b1, 1'b0, 1'b0, 64'hffffffff, 4'b0001};
      dir[5] = '{1'b1, 64'h0,        64'h0,        1'b0, 1'b1, 1'b1, 64'h1,        4'b0000};
      dir[6] = '{1'b1, 64'hffff_ffff_ffff_ffff, 64'h0, 1'b0, 1'b1, 1'b1, 64'h0,   4'b1010};

      #1;
      for (int s = 0; s < 2; s++) begin
         sel = s[0]; #1;
         check("rst_out",      v_out,              64'h0);
         check("rst_flags",    64'(v_flags),       64'h0);
         check("rst_outValid", 64'(v_outValid),    64'h0);
         check("rst_inReady",  64'(v_inReady),     64'h1);
      end
      sel = 1'b0;
      #17 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         sel = dir[i].s; outReady = 1'b1; #1;
         run_op(dir[i].a, dir[i].b, dir[i].m, dir[i].uc, dir[i].ci, r, f, lat);
         check($sformatf("dir%0d_lat", i),   64'(lat), 64'd4);
         check($sformatf("dir%0d_out", i),   r,        dir[i].er);
         check($sformatf("dir%0d_flags", i), 64'(f),   64'(dir[i].ef));
         consume();
      end

      // Backpressure: result held while a second operand waits on inValid.
      sel = 1'b0; outReady = 1'b0; #1;
      run_op(64'h12345678, 64'h11111111, 1'b0, 1'b0, 1'b0, r, f, lat);
      model(64'h12345678, 64'h11111111, 1'b0, 1'b0, 1'b0, 32, er, ef);
      inA = 64'd5; inB = 64'd3; mode = 1'b1; useCarry = 1'b0; cin = 1'b0; inValid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("bp_outValid", 64'(v_outValid), 64'h1);
         check("bp_out",      v_out,           er);
         check("bp_flags",    64'(v_flags),    64'(ef));
         check("bp_inReady",  64'(v_inReady),  64'h0);
      end
      outReady = 1'b1;
      @(posedge clk); #1;
      check("bp_release_vld", 64'(v_outValid), 64'h0);
      check("bp_release_rdy", 64'(v_inReady),  64'h1);
      @(posedge clk); #1;
      check("bp_pending_taken", 64'(v_inReady), 64'h0);
      inValid = 1'b0;
      wait_done(lat);
      check("bp_pending_lat",   64'(lat),     64'd4);
      check("bp_pending_out",   v_out,        64'd2);
      check("bp_pending_carry", 64'(v_flags[3]), 64'h1);
      consume();

      // Reset two cycles into RUN.
      inA = 64'h12345678; inB = 64'h1; mode = 1'b0; useCarry = 1'b0; inValid = 1'b1;
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0; #1;
      check("mid_rst_out",      v_out,           64'h0);
      check("mid_rst_flags",    64'(v_flags),    64'h0);
      check("mid_rst_outValid", 64'(v_outValid), 64'h0);
      check("mid_rst_inReady",  64'(v_inReady),  64'h1);
      #4 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_outValid", 64'(v_outValid), 64'h0);
      check("post_rst_inReady",  64'(v_inReady),  64'h1);
      run_op(64'd1, 64'd1, 1'b0, 1'b0, 1'b0, r, f, lat);
      check("post_rst_sum", r, 64'd2);
      consume();

      for (int i = 0; i < 40; i++) begin
         logic [63:0] a, b;
         logic        m, uc, ci;
         int          stall;
         sel = (i >= 28);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) a = 64'hffff_ffff_ffff_ffff;
         if ($urandom_range(0, 3) == 0) b = sel ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
         m = 1'($urandom_range(0, 1)); uc = 1'($urandom_range(0, 1)); ci = 1'($urandom_range(0, 1));
         outReady = 1'b0; #1;
         run_op(a, b, m, uc, ci, r, f, lat);
         model(a, b, m, uc, ci, sel ? 64 : 32, er, ef);
         check("rnd_lat",   64'(lat), 64'd4);
         check("rnd_out",   r,        er);
         check("rnd_flags", 64'(f),   64'(ef));
         stall = $urandom_range(0, 3);
         for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            check("rnd_hold_out", v_out, er);
         end
         consume();
         check("rnd_idle_flags", 64'(v_flags), 64'(ef));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised, multi-cycle successor to the 32-bit combinational add/sub unit.
- Processes a WIDTH-bit add or subtract SLICE bits per cycle, LSB slice first, with the carry held in a register between slices.
- Reports carry, overFlow, zero and negative flags, and uses valid/ready handshakes on both sides.
- Serves as the area-reduced ALU option and as the multi-precision adder for the ADC/SBB paths.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. WIDTH % SLICE must be 0, otherwise elaboration fails via a generate-time error.
- NSLICE, WIDTH/SLICE, derived local constant; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- inValid  in  1  operand presented.
- inReady  out  1  unit can accept operands.
- inA  in  WIDTH  operand A.
- inB  in  WIDTH  operand B.
- mode  in  1  0 = A+B, 1 = A-B (A + ~B + carry-in).
- useCarry  in  1  1: carry-in = cin; 0: carry-in = mode.
- cin  in  1  external carry-in (ADC/SBB chaining).
- outValid  out  1  result and flags valid.
- outReady  in  1  consumer accepts result.
- out  out  WIDTH  result.
- carry  out  1  carry out of the MSB (for subtract, 1 = no borrow).
- overFlow  out  1  signed overflow.
- zero  out  1  out == 0.
- negative  out  1  out[WIDTH-1].

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; the slice counter clears to 0.
  - out, carry, overFlow, zero, negative and outValid are all 0; inReady is 1 once the state is IDLE.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- IDLE:
  - inReady = 1.
  - On inValid & inReady at a rising edge: latch inA, inB and mode; carry register := useCarry ? cin : mode; clear the result register; clear the counter; go to RUN.
- RUN:
  - inReady = 0.
  - Each cycle, slice i = counter: sum = A[i] + (mode ? ~B[i] : B[i]) + carryReg.
  - Write the sum's low SLICE bits into out[i]; carryReg := sum bit SLICE; counter += 1.
  - Zero is accumulated as AND of "slice == 0" over all slices.
  - On the last slice (counter == NSLICE-1):
    - overFlow := carry into MSB XOR carry out of MSB.
    - negative := result MSB.
    - carry := final carryReg.
    - Go to DONE.
- DONE:
  - outValid = 1. out and all flags are held stable until outValid & outReady.
  - On that handshake: go to IDLE; outValid drops at the same edge.
  - inReady stays 0 in DONE. A new operand is accepted no earlier than the cycle after the output handshake.
- Latency:
  - Input handshake at edge T gives outValid high after edge T+NSLICE.
  - Throughput is one result per NSLICE+2 cycles with outReady tied high.
  - NSLICE = 1 (SLICE == WIDTH) is legal: one RUN cycle.
- Operand capture: inputs are sampled only at the accepting edge. Changes to inA, inB, mode or cin during RUN/DONE have no effect.
- Flag registers update only in RUN on the last slice. In other states they hold their values, including after return to IDLE.
- Width rule: the internal slice adder is SLICE+1 bits wide. No sign extension is applied; signed and unsigned interpretation differ only in which flag the consumer reads.

Decomposition:
- Shared package alu_pkg:
  - State enum {IDLE, RUN, DONE}.
  - MODE_ADD/MODE_SUB constants.
  - A flag struct {carry, overFlow, zero, negative} reused by the future shifter and multiplier units.
- One natural sub-module, addsub_slice: combinational SLICE-bit add/sub slice.
  - Inputs a, b, mode, ci.
  - Outputs s, co, and c_msb_in (carry into the top bit, for overflow).
  - The top-level instantiates it once; the FSM, counter and registers live in addsub_seq.

Test Plan (WIDTH=32, SLICE=8 unless stated):
- Add ffffffff + 00000001, useCarry=0 -> out=00000000, carry=1, overFlow=0, zero=1, negative=0; outValid exactly 4 cycles after the input handshake.
- Add 7fffffff + 7fffffff -> out=fffffffe, carry=0, overFlow=1, negative=1, zero=0. Then 80000000 + 80000000 -> out=0, carry=1, overFlow=1, zero=1.
- Subtract 80000000 - 00000001 -> out=7fffffff, carry=1, overFlow=1. Then 0 - 1 -> out=ffffffff, carry=0, overFlow=0, negative=1.
- Backpressure: hold outReady=0 for 5 cycles in DONE -> out and flags stable, inReady=0, a pending inValid is not taken. Raise outReady -> IDLE next edge; the pending operand is accepted on the following edge.
- Reset mid-RUN: pulse rst_n low after 2 RUN cycles -> all outputs 0 immediately. After release: inReady=1, no outValid, and a fresh 1 + 1 gives out=2.
- WIDTH=64, SLICE=16, useCarry=1, cin=1: add 0 + 0 -> out=1 after 4 cycles. Then ffffffff_ffffffff + 0 with cin=1 -> out=0, carry=1, zero=1.
